sr_latch_arbiter: RTL and testbench
===================================

Name: sr_latch_arbiter

Overview:
- Shares a bank of NUM_LATCH SR latches between two requesters, A and B. The latches are used as hardware flags or semaphores.
- Converts each granted request into a clean set or reset pulse of PULSE_W cycles, waits one settle cycle, then checks the latch q and acks the requester.
- Guarantees the forbidden set=reset=1 input pair never reaches any latch.
- Sits between requester logic and the latch bank's set/reset/q wires.

Parameters:
NUM_LATCH, 4, number of latches driven (1..2**IDX_W)
IDX_W, 2, width of latch index fields
PULSE_W, 2, cycles set/reset is held high (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
req_a  input  1  requester A request, held until ack_a
op_a  input  1  A operation: 1=set latch, 0=reset latch
idx_a  input  IDX_W  A target latch index
ack_a  output  1  one-cycle completion pulse to A
req_b  input  1  requester B request, held until ack_b
op_b  input  1  B operation, same encoding as op_a
idx_b  input  IDX_W  B target latch index
ack_b  output  1  one-cycle completion pulse to B
err  output  1  valid only with ack_a/ack_b; 1=index invalid or q mismatch
busy  output  1  high in every state except IDLE
latch_set  output  NUM_LATCH  per-latch set drive
latch_reset  output  NUM_LATCH  per-latch reset drive
latch_q  input  NUM_LATCH  per-latch q feedback

Behaviour:
- All outputs are registered.
- Reset (rst=1 at an edge):
  - State goes to IDLE; ack_a, ack_b, err, busy, latch_set and latch_reset are all 0.
  - The round-robin pointer is set to "B last", so A wins the first tie.
  - Latch contents are not touched.
  - Reset mid-DRIVE truncates the pulse; the in-flight request gets no ack.
- FSM states: IDLE, DRIVE, SETTLE, DONE.
- IDLE:
  - Sample req_a/req_b.
  - Neither high: stay in IDLE.
  - One high: grant it.
  - Both high: grant the one not granted last; the loser keeps req high and waits.
  - On grant, capture op, idx and requester id, and update the pointer.
  - Valid idx (idx < NUM_LATCH): go to DRIVE.
  - Invalid idx: go directly to SETTLE with an invalid flag set. No latch is driven.
- DRIVE:
  - op=1: latch_set[idx]=1. op=0: latch_reset[idx]=1. All other bits are 0.
  - Held for exactly PULSE_W cycles (down-counter), then go to SETTLE.
- SETTLE:
  - latch_set and latch_reset are all 0 for one cycle.
  - At the end of this cycle, sample latch_q[idx] into a mismatch flag: mismatch = (q != op).
- DONE:
  - Assert ack of the captured requester for one cycle.
  - err = invalid | mismatch.
  - Return to IDLE.
- Invariants:
  - At most one bit of (latch_set | latch_reset) is high in any cycle.
  - latch_set[i] and latch_reset[i] are never both 1.
- Latency: req seen in IDLE at cycle 0 -> drive in cycles 1..PULSE_W -> settle in cycle PULSE_W+1 -> ack in cycle PULSE_W+2. With defaults the ack is at cycle 4.
- Invalid idx: ack at cycle 2, with err=1.
- Throughput: a request held high through its ack is re-sampled in the IDLE cycle after DONE. Requesters must drop req on the edge that samples ack, or the request is treated as a new one.
- Changing op/idx while req is high before grant is allowed; the values are captured at grant. Changes after grant are ignored.
- Setting an already-set latch, or resetting an already-reset latch, still drives the full pulse and acks with err=0 if q matches.

Test Plan:
1. After rst, req_a=1, op_a=1, idx_a=2 with the latch model responding:
   - latch_set=4'b0100 in cycles 1-2, all drives 0 in cycle 3.
   - ack_a=1 and err=0 in cycle 4; busy=1 in cycles 1-4.
2. req_a and req_b both high from IDLE after reset:
   - A is served first (ack_a at cycle 4).
   - B is granted in the next IDLE, cycle 5, and ack_b arrives at cycle 9.
   - Repeating the tie then grants B first.
3. Set latch 1, then reset latch 1 via B:
   - latch_reset=4'b0010 for 2 cycles, ack_b with err=0.
   - The latch model q[1] reads 0.
4. NUM_LATCH=3, req_b with idx_b=3:
   - latch_set and latch_reset stay 0 throughout.
   - ack_b=1 with err=1 at cycle 2.
5. Latch model q stuck at 0, req_a op=1 idx=0:
   - Full pulse on latch_set[0].
   - ack_a with err=1 at cycle 4.
6. rst asserted in the first DRIVE cycle:
   - Next edge: latch_set=0, busy=0, no ack.
   - A request re-issued afterwards completes normally.
- All scenarios: a checker asserts every cycle that (latch_set & latch_reset)==0 and that at most one drive bit is high.

Source files
------------

// File: rtl/sr_latch_arbiter.sv
// sr_latch_arbiter: shares a bank of SR latches between requesters A and B.
// Each granted request becomes a clean set or reset pulse of PULSE_W cycles,
// then a settle cycle, a q check, and a one-cycle ack to the requester.
//
//   state  | meaning
//   IDLE   | waiting for req_a/req_b; round-robin grant on a tie
//   DRIVE  | set or reset pulse held on the captured latch
//   SETTLE | all drives low; latch q sampled at the end of the cycle
//   DONE   | ack to the captured requester, err = invalid | mismatch
module sr_latch_arbiter #(
  parameter int NUM_LATCH = 4,
  parameter int IDX_W     = 2,
  parameter int PULSE_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_a,
  input  logic                 op_a,
  input  logic [IDX_W-1:0]     idx_a,
  output logic                 ack_a,
  input  logic                 req_b,
  input  logic                 op_b,
  input  logic [IDX_W-1:0]     idx_b,
  output logic                 ack_b,
  output logic                 err,
  output logic                 busy,
  output logic [NUM_LATCH-1:0] latch_set,
  output logic [NUM_LATCH-1:0] latch_reset,
  input  logic [NUM_LATCH-1:0] latch_q
);

  localparam int NSLOT = 1 << IDX_W;
  localparam int CNT_W = $clog2(PULSE_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_W - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 op_q, op_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 id_b_q, id_b_d;
  logic                 invalid_q, invalid_d;
  logic                 last_b_q, last_b_d;
  logic                 ack_a_q, ack_a_d;
  logic                 ack_b_q, ack_b_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [NUM_LATCH-1:0] set_q, set_d;
  logic [NUM_LATCH-1:0] reset_q, reset_d;

  logic                 grant_a, grant_b;
  logic [NSLOT-1:0]     q_pad;
  logic [NSLOT-1:0]     slot_hot;
  logic [NUM_LATCH-1:0] drv;

  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign latch_set   = set_q;
  assign latch_reset = reset_q;

  // Next-state, capture and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    idx_d     = idx_q;
    id_b_d    = id_b_q;
    invalid_d = invalid_q;
    last_b_d  = last_b_q;
    err_d     = 1'b0;
    // q is zero-padded so an out-of-range index can be read safely; the
    // invalid flag masks its value anyway.
    q_pad     = NSLOT'(latch_q);
    // On a tie, the requester that was not granted last wins.
    grant_a   = req_a & (~req_b | last_b_q);
    grant_b   = req_b & (~req_a | ~last_b_q);

    case (state_q)
      IDLE: begin
        if (grant_a | grant_b) begin
          id_b_d    = grant_b;
          last_b_d  = grant_b;
          op_d      = grant_b ? op_b : op_a;
          idx_d     = grant_b ? idx_b : idx_a;
          invalid_d = int'(idx_d) >= NUM_LATCH;
          cnt_d     = CNT_LOAD;
          state_d   = invalid_d ? SETTLE : DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) state_d = SETTLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SETTLE: begin
        state_d = DONE;
        err_d   = invalid_q | (q_pad[idx_q] != op_q);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Only one one-hot vector exists and it goes to either set or reset,
    // so set=reset=1 can never be produced on any latch.
    slot_hot = NSLOT'(1) << idx_d;
    drv      = (state_d == DRIVE) ? NUM_LATCH'(slot_hot) : '0;
    set_d    = op_d ? drv : '0;
    reset_d  = op_d ? '0 : drv;
    ack_a_d  = (state_d == DONE) & ~id_b_d;
    ack_b_d  = (state_d == DONE) & id_b_d;
    busy_d   = state_d != IDLE;
  end

  // State, capture and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      idx_q     <= '0;
      id_b_q    <= 1'b0;
      invalid_q <= 1'b0;
      last_b_q  <= 1'b1;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      set_q     <= '0;
      reset_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      id_b_q    <= id_b_d;
      invalid_q <= invalid_d;
      last_b_q  <= last_b_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      set_q     <= set_d;
      reset_q   <= reset_d;
    end
  end

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Directed bench for sr_latch_arbiter: a 4-latch instance with a behavioural
// latch model and a 3-latch instance for the invalid-index case.
module tb_sr_latch_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       req_a = 0, op_a = 0, req_b = 0, op_b = 0;
  logic [1:0] idx_a = 0, idx_b = 0;
  logic       ack_a, ack_b, err, busy;
  logic [3:0] latch_set, latch_reset, latch_q;
  logic [3:0] mdl_q = 4'b0000;
  logic [3:0] stuck = 4'b0000;

  logic       req_a3 = 0, op_a3 = 0, req_b3 = 0, op_b3 = 0;
  logic [1:0] idx_a3 = 0, idx_b3 = 0;
  logic       ack_a3, ack_b3, err3, busy3;
  logic [2:0] set3, reset3;
  logic [2:0] q3 = 3'b000;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sr_latch_arbiter #(.NUM_LATCH(4), .IDX_W(2), .PULSE_W(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .op_a(op_a), .idx_a(idx_a), .ack_a(ack_a),
    .req_b(req_b), .op_b(op_b), .idx_b(idx_b), .ack_b(ack_b),
    .err(err), .busy(busy),
    .latch_set(latch_set), .latch_reset(latch_reset), .latch_q(latch_q)
  );

  sr_latch_arbiter #(.NUM_LATCH(3), .IDX_W(2), .PULSE_W(2)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_a(req_a3), .op_a(op_a3), .idx_a(idx_a3), .ack_a(ack_a3),
    .req_b(req_b3), .op_b(op_b3), .idx_b(idx_b3), .ack_b(ack_b3),
    .err(err3), .busy(busy3),
    .latch_set(set3), .latch_reset(reset3), .latch_q(q3)
  );

  // SR latch bank model; stuck bits force the q seen by the DUT to 0.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (latch_set[i])        mdl_q[i] <= 1'b1;
      else if (latch_reset[i]) mdl_q[i] <= 1'b0;
    end
  end
  assign latch_q = mdl_q & ~stuck;

  // Drive-safety invariants on both instances, every cycle.
  always @(negedge clk) begin
    n_cmp++;
    if ((latch_set & latch_reset) !== 4'b0000 || $countones(latch_set | latch_reset) > 1) begin
      n_bad++;
      $display("FAIL inv_drive4 got set=%b reset=%b want disjoint one-hot-or-zero", latch_set, latch_reset);
    end
    n_cmp++;
    if ((set3 & reset3) !== 3'b000 || $countones(set3 | reset3) > 1) begin
      n_bad++;
      $display("FAIL inv_drive3 got set=%b reset=%b want disjoint one-hot-or-zero", set3, reset3);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Waits up to 20 cycles for an ack; n = cycles waited, -1 on timeout.
  task automatic wait_ack(input bit on_b, output int n);
    n = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if ((on_b ? ack_b : ack_a) === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (ack_a !== 1'b0)  begin n_bad++; $display("FAIL rst_ack_a got %b want 0", ack_a); end
    n_cmp++; if (ack_b !== 1'b0)  begin n_bad++; $display("FAIL rst_ack_b got %b want 0", ack_b); end
    n_cmp++; if (err !== 1'b0)    begin n_bad++; $display("FAIL rst_err got %b want 0", err); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (latch_set !== 4'b0000)   begin n_bad++; $display("FAIL rst_set got %b want 0000", latch_set); end
    n_cmp++; if (latch_reset !== 4'b0000) begin n_bad++; $display("FAIL rst_reset got %b want 0000", latch_reset); end
    n_cmp++; if (busy3 !== 1'b0)  begin n_bad++; $display("FAIL rst_busy3 got %b want 0", busy3); end
    rst = 1'b0;
  endtask

  task automatic test_single_set();
    do_reset();
    req_a = 1; op_a = 1; idx_a = 2'd2;
    tick();
    n_cmp++; if (latch_set !== 4'b0100)   begin n_bad++; $display("FAIL t1_set_c1 got %b want 0100", latch_set); end
    n_cmp++; if (latch_reset !== 4'b0000) begin n_bad++; $display("FAIL t1_reset_c1 got %b want 0000", latch_reset); end
    n_cmp++; if (busy !== 1'b1)           begin n_bad++; $display("FAIL t1_busy_c1 got %b want 1", busy); end
    tick();
    n_cmp++; if (latch_set !== 4'b0100)   begin n_bad++; $display("FAIL t1_set_c2 got %b want 0100", latch_set); end
    tick();
    n_cmp++; if (latch_set !== 4'b0000)   begin n_bad++; $display("FAIL t1_set_c3 got %b want 0000", latch_set); end
    n_cmp++; if (busy !== 1'b1 || ack_a !== 1'b0) begin n_bad++; $display("FAIL t1_c3 got busy=%b ack_a=%b want 1/0", busy, ack_a); end
    tick();
    n_cmp++; if (ack_a !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL t1_ack_c4 got ack_a=%b err=%b want 1/0", ack_a, err); end
    n_cmp++; if (busy !== 1'b1)           begin n_bad++; $display("FAIL t1_busy_c4 got %b want 1", busy); end
    req_a = 0;
    tick();
    n_cmp++; if (busy !== 1'b0 || ack_a !== 1'b0) begin n_bad++; $display("FAIL t1_c5 got busy=%b ack_a=%b want 0/0", busy, ack_a); end
    n_cmp++; if (mdl_q[2] !== 1'b1)       begin n_bad++; $display("FAIL t1_q2 got %b want 1", mdl_q[2]); end
  endtask

  task automatic test_tie();
    int n;
    do_reset();
    req_a = 1; op_a = 1; idx_a = 2'd0;
    req_b = 1; op_b = 1; idx_b = 2'd3;
    wait_ack(1'b0, n);
    n_cmp++; if (n !== 4)        begin n_bad++; $display("FAIL t2_a_first got %0d want 4", n); end
    n_cmp++; if (ack_b !== 1'b0) begin n_bad++; $display("FAIL t2_b_wait got %b want 0", ack_b); end
    req_a = 0;
    tick();
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL t2_idle_c5 got busy=%b want 0", busy); end
    tick();
    n_cmp++; if (latch_set !== 4'b1000) begin n_bad++; $display("FAIL t2_b_drive_c6 got %b want 1000", latch_set); end
    wait_ack(1'b1, n);
    n_cmp++; if (n !== 3)        begin n_bad++; $display("FAIL t2_b_ack_c9 got %0d want 3", n); end
    req_b = 0;
    tick();
    // A-only transaction, so A becomes the last granted requester.
    req_a = 1; op_a = 0; idx_a = 2'd0;
    wait_ack(1'b0, n);
    n_cmp++; if (n !== 4)        begin n_bad++; $display("FAIL t2_a_solo got %0d want 4", n); end
    req_a = 0;
    tick();
    req_a = 1; op_a = 1; idx_a = 2'd2;
    req_b = 1; op_b = 1; idx_b = 2'd1;
    tick();
    n_cmp++; if (latch_set !== 4'b0010) begin n_bad++; $display("FAIL t2_tie_b_first got %b want 0010", latch_set); end
    wait_ack(1'b1, n);
    n_cmp++; if (n !== 3)        begin n_bad++; $display("FAIL t2_tie_b_ack got %0d want 3", n); end
    req_b = 0;
    wait_ack(1'b0, n);
    n_cmp++; if (n !== 5)        begin n_bad++; $display("FAIL t2_tie_a_second got %0d want 5", n); end
    req_a = 0;
    tick();
  endtask

  task automatic test_set_then_reset();
    int n;
    req_a = 1; op_a = 1; idx_a = 2'd1;
    wait_ack(1'b0, n);
    n_cmp++; if (n !== 4 || err !== 1'b0) begin n_bad++; $display("FAIL t3_set got n=%0d err=%b want 4/0", n, err); end
    req_a = 0;
    tick();
    n_cmp++; if (mdl_q[1] !== 1'b1) begin n_bad++; $display("FAIL t3_q1_set got %b want 1", mdl_q[1]); end
    req_b = 1; op_b = 0; idx_b = 2'd1;
    tick();
    n_cmp++; if (latch_reset !== 4'b0010 || latch_set !== 4'b0000) begin n_bad++; $display("FAIL t3_rst_c1 got reset=%b set=%b want 0010/0000", latch_reset, latch_set); end
    tick();
    n_cmp++; if (latch_reset !== 4'b0010) begin n_bad++; $display("FAIL t3_rst_c2 got %b want 0010", latch_reset); end
    wait_ack(1'b1, n);
    n_cmp++; if (n !== 2 || err !== 1'b0) begin n_bad++; $display("FAIL t3_ack_b got n=%0d err=%b want 2/0", n, err); end
    req_b = 0;
    tick();
    n_cmp++; if (mdl_q[1] !== 1'b0) begin n_bad++; $display("FAIL t3_q1_reset got %b want 0", mdl_q[1]); end
    // Resetting an already-reset latch still completes cleanly.
    req_b = 1; op_b = 0; idx_b = 2'd1;
    wait_ack(1'b1, n);
    n_cmp++; if (n !== 4 || err !== 1'b0) begin n_bad++; $display("FAIL t3_rereset got n=%0d err=%b want 4/0", n, err); end
    req_b = 0;
    tick();
  endtask

  task automatic test_invalid_idx();
    req_b3 = 1; op_b3 = 1; idx_b3 = 2'd3;
    tick();
    n_cmp++; if (set3 !== 3'b000 || reset3 !== 3'b000) begin n_bad++; $display("FAIL t4_drive_c1 got set=%b reset=%b want 000/000", set3, reset3); end
    n_cmp++; if (busy3 !== 1'b1 || ack_b3 !== 1'b0) begin n_bad++; $display("FAIL t4_c1 got busy=%b ack=%b want 1/0", busy3, ack_b3); end
    tick();
    n_cmp++; if (ack_b3 !== 1'b1 || err3 !== 1'b1) begin n_bad++; $display("FAIL t4_ack_c2 got ack=%b err=%b want 1/1", ack_b3, err3); end
    n_cmp++; if (set3 !== 3'b000 || reset3 !== 3'b000) begin n_bad++; $display("FAIL t4_drive_c2 got set=%b reset=%b want 000/000", set3, reset3); end
    req_b3 = 0;
    tick();
    n_cmp++; if (busy3 !== 1'b0 || ack_b3 !== 1'b0) begin n_bad++; $display("FAIL t4_c3 got busy=%b ack=%b want 0/0", busy3, ack_b3); end
    req_a3 = 1; op_a3 = 0; idx_a3 = 2'd2;
    tick();
    n_cmp++; if (reset3 !== 3'b100) begin n_bad++; $display("FAIL t4_valid_c1 got %b want 100", reset3); end
    tick();
    tick();
    tick();
    n_cmp++; if (ack_a3 !== 1'b1 || err3 !== 1'b0) begin n_bad++; $display("FAIL t4_valid_ack got ack=%b err=%b want 1/0", ack_a3, err3); end
    req_a3 = 0;
    tick();
  endtask

  task automatic test_mismatch();
    int n;
    stuck = 4'b0001;
    req_a = 1; op_a = 1; idx_a = 2'd0;
    tick();
    n_cmp++; if (latch_set !== 4'b0001) begin n_bad++; $display("FAIL t5_set_c1 got %b want 0001", latch_set); end
    tick();
    n_cmp++; if (latch_set !== 4'b0001) begin n_bad++; $display("FAIL t5_set_c2 got %b want 0001", latch_set); end
    wait_ack(1'b0, n);
    n_cmp++; if (n !== 2 || err !== 1'b1) begin n_bad++; $display("FAIL t5_ack_err got n=%0d err=%b want 2/1", n, err); end
    req_a = 0;
    tick();
    stuck = 4'b0000;
  endtask

  task automatic test_reset_mid_drive();
    int n;
    req_a = 1; op_a = 1; idx_a = 2'd3;
    tick();
    n_cmp++; if (latch_set !== 4'b1000 || busy !== 1'b1) begin n_bad++; $display("FAIL t6_drive_c1 got set=%b busy=%b want 1000/1", latch_set, busy); end
    rst = 1'b1;
    req_a = 0;
    tick();
    n_cmp++; if (latch_set !== 4'b0000 || busy !== 1'b0 || ack_a !== 1'b0) begin n_bad++; $display("FAIL t6_trunc got set=%b busy=%b ack=%b want 0000/0/0", latch_set, busy, ack_a); end
    rst = 1'b0;
    tick();
    tick();
    n_cmp++; if (ack_a !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL t6_no_ack got ack=%b busy=%b want 0/0", ack_a, busy); end
    req_a = 1; op_a = 0; idx_a = 2'd3;
    tick();
    n_cmp++; if (latch_reset !== 4'b1000) begin n_bad++; $display("FAIL t6_reissue_c1 got %b want 1000", latch_reset); end
    wait_ack(1'b0, n);
    n_cmp++; if (n !== 3 || err !== 1'b0) begin n_bad++; $display("FAIL t6_reissue_ack got n=%0d err=%b want 3/0", n, err); end
    req_a = 0;
    tick();
    n_cmp++; if (mdl_q[3] !== 1'b0) begin n_bad++; $display("FAIL t6_q3 got %b want 0", mdl_q[3]); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_set();
    test_tie();
    test_set_then_reset();
    test_invalid_idx();
    test_mismatch();
    test_reset_mid_drive();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
